// File: rtl/video_fetch.sv
// Framebuffer video-port reader: fetches 32-bit words into a 2-entry FIFO and emits RGB332 pixels.
// Optional build macro VIDEO_FETCH_TESTPATTERN_EN replaces pixel data with source_x ^ vline.
module video_fetch #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          LINE_WORDS = 40,
    parameter int          LINES      = 48,
    parameter int          H_REPEAT   = 4,
    parameter int          V_REPEAT   = 10
) (
    input  logic        clk_pixel,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        pixel_en,
    output logic [15:0] video_raddr,
    input  logic [31:0] video_rdata,
    output logic [7:0]  pixel,
    output logic        pixel_valid,
    output logic        underrun
);

    localparam int              WC_W         = $clog2(LINE_WORDS + 1);
    localparam logic [WC_W-1:0] LINE_WORDS_C = WC_W'(LINE_WORDS);
    localparam logic [WC_W-1:0] LAST_WORD_C  = WC_W'(LINE_WORDS - 1);
    localparam logic [15:0]     LINE_BYTES   = 16'(LINE_WORDS * 4);
    localparam logic [15:0]     LINES_C      = 16'(LINES);
    localparam logic [3:0]      H_LAST       = 4'(H_REPEAT - 1);
    localparam logic [3:0]      V_LAST       = 4'(V_REPEAT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t            state;
    logic [15:0]       line_base;
    logic [15:0]       fetch_addr;
    logic [15:0]       vline;
    logic [3:0]        vrep;
    logic              first_line;
    logic [WC_W-1:0]   words_issued;
    logic [WC_W-1:0]   words_consumed;
    logic [1:0]        byte_idx;
    logic [3:0]        hcnt;

    logic [31:0]       fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;
    logic              rd_vld_p1;

    logic              flush;
    logic              can_issue;
    logic              push;
    logic              pop;
    logic              show;
    logic              starve;
    logic [7:0]        pix_data;

    logic [15:0]       ln_base;
    logic [15:0]       ln_vline;
    logic [3:0]        ln_vrep;
    logic [15:0]       base_c;
    logic [15:0]       vline_c;
    logic [3:0]        vrep_c;
    logic              first_c;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // The address is live whenever a read is issued; the RAM answers one cycle later.
    assign video_raddr = fetch_addr;

    assign flush     = frame_start | line_start;
    assign can_issue = (state == FETCH) && (words_issued != LINE_WORDS_C) &&
                       ((occ + {1'b0, rd_vld_p1}) < 2'd2) && !flush;
    assign push      = rd_vld_p1 && !flush;
    assign show      = pixel_en && (state == FETCH) && (occ != 2'd0);
    assign starve    = pixel_en && (state == FETCH) && (occ == 2'd0);
    assign pop       = show && (hcnt == H_LAST) && (byte_idx == 2'd3) && !flush;

`ifdef VIDEO_FETCH_TESTPATTERN_EN
    logic [7:0] src_x;
    assign src_x    = 8'({words_consumed, byte_idx});
    assign pix_data = src_x ^ vline[7:0];
`else
    assign pix_data = word_byte(fifo_mem[rd_ptr], byte_idx);
`endif

    // A same-cycle frame_start is folded in first so line_start then opens line 0.
    always_comb begin
        base_c   = frame_start ? BASE_ADDR : line_base;
        vline_c  = frame_start ? 16'd0 : vline;
        vrep_c   = frame_start ? 4'd0 : vrep;
        first_c  = frame_start | first_line;
        ln_base  = base_c;
        ln_vline = vline_c;
        ln_vrep  = vrep_c;
        if (!first_c) begin
            if (vrep_c == V_LAST) begin
                ln_vrep  = 4'd0;
                ln_vline = vline_c + 16'd1;
                ln_base  = base_c + LINE_BYTES;
            end else begin
                ln_vrep  = vrep_c + 4'd1;
            end
        end
    end

    // Stage p1: returned word lands in the FIFO (data path, not reset).
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_mem[wr_ptr] <= video_rdata;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            state          <= IDLE;
            line_base      <= BASE_ADDR;
            fetch_addr     <= BASE_ADDR;
            vline          <= 16'd0;
            vrep           <= 4'd0;
            first_line     <= 1'b1;
            words_issued   <= '0;
            words_consumed <= '0;
            byte_idx       <= 2'd0;
            hcnt           <= 4'd0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            occ            <= 2'd0;
            rd_vld_p1      <= 1'b0;
            pixel          <= 8'd0;
            pixel_valid    <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            rd_vld_p1   <= can_issue;
            pixel       <= show ? pix_data : 8'd0;
            pixel_valid <= show;
            if (frame_start) begin
                underrun <= 1'b0;
            end else if (starve) begin
                underrun <= 1'b1;
            end

            if (line_start) begin
                line_base      <= ln_base;
                vline          <= ln_vline;
                vrep           <= ln_vrep;
                first_line     <= 1'b0;
                fetch_addr     <= ln_base;
                words_issued   <= '0;
                words_consumed <= '0;
                byte_idx       <= 2'd0;
                hcnt           <= 4'd0;
                wr_ptr         <= 1'b0;
                rd_ptr         <= 1'b0;
                occ            <= 2'd0;
                state          <= (ln_vline >= LINES_C) ? DONE : FETCH;
            end else if (frame_start) begin
                line_base  <= BASE_ADDR;
                vline      <= 16'd0;
                vrep       <= 4'd0;
                first_line <= 1'b1;
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                occ        <= 2'd0;
                state      <= IDLE;
            end else begin
                if (can_issue) begin
                    fetch_addr   <= fetch_addr + 16'd4;
                    words_issued <= words_issued + WC_W'(1);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + 2'd1;
                    2'b01:   occ <= occ - 2'd1;
                    default: occ <= occ;
                endcase
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                // Starved strobes leave the position untouched so the line resumes intact.
                if (show) begin
                    if (hcnt == H_LAST) begin
                        hcnt     <= 4'd0;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            words_consumed <= words_consumed + WC_W'(1);
                            if (words_consumed == LAST_WORD_C) begin
                                state <= DONE;
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_fetch.sv
// Scoreboard bench for video_fetch: random pixel strobes against a source-pixel reference model.
// Honours VIDEO_FETCH_TESTPATTERN_EN the same way the design does.
module tb_video_fetch;

    localparam logic [15:0] BASE    = 16'h0000;
    localparam int          LW      = 40;
    localparam int          NL      = 48;
    localparam int          HR      = 4;
    localparam int          VR      = 10;
    localparam int          SRC_PIX = LW * 4;
    // Word 0 is requested the cycle after line_start, returns a cycle later and is usable the next.
    localparam int          FIRST_USABLE = 3;

    logic        clk_pixel = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        pixel_en = 1'b0;
    logic [15:0] video_raddr;
    logic [31:0] video_rdata;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        underrun;

    always #5 clk_pixel = ~clk_pixel;

    video_fetch #(
        .BASE_ADDR (BASE),
        .LINE_WORDS(LW),
        .LINES     (NL),
        .H_REPEAT  (HR),
        .V_REPEAT  (VR)
    ) dut (
        .clk_pixel  (clk_pixel),
        .resetn     (resetn),
        .frame_start(frame_start),
        .line_start (line_start),
        .pixel_en   (pixel_en),
        .video_raddr(video_raddr),
        .video_rdata(video_rdata),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .underrun   (underrun)
    );

    logic [31:0] mem [0:16383];
    always @(posedge clk_pixel) video_rdata <= mem[video_raddr[15:2]];

    typedef struct packed {
        logic       valid;
        logic [7:0] pix;
        logic       und;
    } exp_t;

    exp_t        pix_q[$];
    logic [15:0] addr_q[$];
    int          total = 0;
    int          bad = 0;

    int m_vline, m_vrep, m_pos, m_hc, m_cyc;
    bit m_first, m_active, m_und;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] line_addr(input int v);
        return 16'(int'(BASE) + v * LW * 4);
    endfunction

    function automatic logic [7:0] src_pixel(input int v, input int pos);
        int          wi;
        logic [31:0] w;
        wi = (int'(line_addr(v)) >> 2) + pos / 4;
        w  = mem[wi & 16383];
`ifdef VIDEO_FETCH_TESTPATTERN_EN
        return 8'(pos) ^ 8'(v);
`else
        return 8'(w >> (8 * (pos % 4)));
`endif
    endfunction

    task automatic model_reset();
        m_vline = 0; m_vrep = 0; m_pos = 0; m_hc = 0; m_cyc = 1000;
        m_first = 1'b1; m_active = 1'b0; m_und = 1'b0;
    endtask

    // One pixel-clock cycle of stimulus; the model is updated with the same inputs.
    task automatic step(input bit fs, input bit ls, input bit pe);
        exp_t e;
        frame_start = fs;
        line_start  = ls;
        pixel_en    = pe;
        m_cyc++;
        if (fs) begin
            m_vline = 0; m_vrep = 0; m_first = 1'b1; m_active = 1'b0; m_und = 1'b0;
        end
        if (ls) begin
            if (!m_first) begin
                m_vrep++;
                if (m_vrep == VR) begin
                    m_vrep = 0;
                    m_vline++;
                end
            end
            m_first = 1'b0; m_active = 1'b1; m_pos = 0; m_hc = 0; m_cyc = 0;
            addr_q.push_back(line_addr(m_vline));
        end
        if (pe) begin
            e.valid = 1'b0;
            e.pix   = 8'd0;
            if (!m_active || m_vline >= NL || m_pos >= SRC_PIX) begin
                e.und = m_und;
            end else if (m_cyc < FIRST_USABLE) begin
                m_und = 1'b1;
                e.und = 1'b1;
            end else begin
                e.valid = 1'b1;
                e.pix   = src_pixel(m_vline, m_pos);
                e.und   = m_und;
                m_hc++;
                if (m_hc == HR) begin
                    m_hc = 0;
                    m_pos++;
                end
            end
            pix_q.push_back(e);
        end
        @(posedge clk_pixel);
        #1;
    endtask

    // Monitor: pops an expectation for every strobed pixel and checks line start addresses.
    initial begin
        bit          pen_prev, ls_prev;
        exp_t        e;
        logic [15:0] a;
        forever begin
            @(posedge clk_pixel);
            pen_prev = pixel_en;
            ls_prev  = line_start;
            @(negedge clk_pixel);
            if (pen_prev) begin
                if (pix_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pixel_queue actual=output required=expectation at %0t", $time);
                end else begin
                    e = pix_q.pop_front();
                    check("pixel_valid", pixel_valid, e.valid);
                    check("pixel", pixel, e.pix);
                    check("underrun", underrun, e.und);
                end
            end else begin
                check("idle_valid", pixel_valid, 1'b0);
                check("idle_pixel", pixel, 8'd0);
            end
            if (ls_prev && addr_q.size() != 0) begin
                a = addr_q.pop_front();
                check("line_addr", video_raddr, a);
            end
        end
    end

    initial begin
        #100000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h44332211;
        model_reset();

        repeat (2) @(posedge clk_pixel);
        #1;
        check("rst_raddr", video_raddr, 16'h0000);
        check("rst_underrun", underrun, 1'b0);
        resetn = 1'b1;

        // Known word 0 with both pulses together, then a pause so the FIFO fills.
        step(1, 1, 0);
        repeat (3) step(0, 0, 0);
        repeat (36) step(0, 0, 1);
        repeat (4) step(0, 0, 0);

        resetn = 1'b0;
        @(posedge clk_pixel);
        #1;
        check("rst2_raddr", video_raddr, 16'h0000);
        check("rst2_pixel", pixel, 8'd0);
        check("rst2_valid", pixel_valid, 1'b0);
        check("rst2_underrun", underrun, 1'b0);
        resetn = 1'b1;
        model_reset();
        repeat (2) step(0, 0, 1);

        // Strobe too early, then resume once data is available.
        step(1, 1, 0);
        step(0, 0, 1);
        repeat (2) step(0, 0, 0);
        repeat (24) step(0, 0, 1);
        step(1, 0, 0);
        repeat (3) step(0, 0, 1);

        // Full frame plus two lines past the end.
        for (int ln = 0; ln < NL * VR + 2; ln++) begin
            step(0, 1, 0);
            repeat (3) step(0, 0, 0);
            if (ln == 0 || ln == 30 || ln == NL * VR - 1) begin
                n = 0;
                while (n < SRC_PIX * HR + 8) begin
                    if (($urandom % 4) != 0) begin
                        step(0, 0, 1);
                        n++;
                    end else begin
                        step(0, 0, 0);
                    end
                end
            end else begin
                n = $urandom_range(0, 60);
                for (int k = 0; k < n; k++) step(0, 0, 1'($urandom % 2));
            end
        end
        repeat (4) step(0, 0, 0);

        check("pixel_queue_left", pix_q.size(), 0);
        check("addr_queue_left", addr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
